// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory arbiter: FSM state
// encodings, grant identifiers and the latched bus command layout.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_LS_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_LS = 1'b1
    } grant_e;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_cmd_t;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr & WORD_MASK;
    endfunction

    function automatic bus_cmd_t make_fetch_cmd(input logic [31:0] byte_addr);
        bus_cmd_t cmd;
        cmd.we    = 1'b0;
        cmd.addr  = word_addr(byte_addr);
        cmd.wdata = 32'h0000_0000;
        cmd.wstrb = 4'b0000;
        return cmd;
    endfunction

    // Loads never drive strobes onto the bus, whatever the LSU leaves on wstrb
    function automatic bus_cmd_t make_ls_cmd(input logic        we,
                                             input logic [31:0] byte_addr,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
        bus_cmd_t cmd;
        cmd.we    = we;
        cmd.addr  = word_addr(byte_addr);
        cmd.wdata = wdata;
        cmd.wstrb = we ? wstrb : 4'b0000;
        return cmd;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory interface between instruction fetch and the
// load/store unit, one outstanding transaction at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_ce,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_br_en,
    output logic [31:0] o_if_data,
    output logic        o_if_valid,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_wstrb,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_ack,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_hz_mem
);

    arb_state_e  state_r, state_s;
    grant_e      last_grant_r, last_grant_s;
    logic        discard_r, discard_s;
    bus_cmd_t    cmd_r, cmd_s;
    logic        mem_req_r, mem_req_s;
    logic [31:0] if_data_r, if_data_s;
    logic [31:0] ls_rdata_r, ls_rdata_s;
    logic        if_valid_r, if_valid_s;
    logic        ls_ack_r, ls_ack_s;
    logic        if_elig_s, ls_elig_s;
    logic        grant_if_s, grant_ls_s;

    // A held level request is blind while its own response pulse is high,
    // so one request can never be granted twice
    always_comb begin
        if_elig_s  = i_if_req && !if_valid_r;
        ls_elig_s  = i_ls_req && !ls_ack_r;
        grant_if_s = if_elig_s && (!ls_elig_s || (last_grant_r == GRANT_LS));
        grant_ls_s = ls_elig_s && !grant_if_s;
    end

    // Next state, bus command latch and return-path update
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        discard_s    = discard_r;
        cmd_s        = cmd_r;
        mem_req_s    = mem_req_r;
        if_data_s    = if_data_r;
        ls_rdata_s   = ls_rdata_r;
        if_valid_s   = 1'b0;
        ls_ack_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_if_s) begin
                    cmd_s     = make_fetch_cmd(i_if_addr);
                    mem_req_s = 1'b1;
                    state_s   = ST_IF_BUSY;
                end else if (grant_ls_s) begin
                    cmd_s     = make_ls_cmd(i_ls_we, i_ls_addr, i_ls_wdata, i_ls_wstrb);
                    mem_req_s = 1'b1;
                    state_s   = ST_LS_BUSY;
                end else begin
                    mem_req_s = 1'b0;
                end
            end
            ST_IF_BUSY: begin
                if (i_mem_ack) begin
                    // A branch in the completion cycle still kills the data
                    if (discard_r || i_br_en) begin
                        if_valid_s = 1'b0;
                    end else begin
                        if_data_s  = i_mem_rdata;
                        if_valid_s = 1'b1;
                    end
                    discard_s    = 1'b0;
                    mem_req_s    = 1'b0;
                    last_grant_s = GRANT_IF;
                    state_s      = ST_IDLE;
                end else if (i_br_en) begin
                    discard_s = 1'b1;
                end else begin
                    discard_s = discard_r;
                end
            end
            ST_LS_BUSY: begin
                if (i_mem_ack) begin
                    if (cmd_r.we) begin
                        ls_rdata_s = ls_rdata_r;
                    end else begin
                        ls_rdata_s = i_mem_rdata;
                    end
                    ls_ack_s     = 1'b1;
                    mem_req_s    = 1'b0;
                    last_grant_s = GRANT_LS;
                    state_s      = ST_IDLE;
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
                discard_s = 1'b0;
            end
        endcase
    end

    // Arbitration state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GRANT_IF;
            discard_r    <= 1'b0;
        end else if (i_clk_ce) begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            discard_r    <= discard_s;
        end
    end

    // Bus command and requester return registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_r      <= make_fetch_cmd(32'h0000_0000);
            mem_req_r  <= 1'b0;
            if_data_r  <= 32'h0000_0000;
            ls_rdata_r <= 32'h0000_0000;
            if_valid_r <= 1'b0;
            ls_ack_r   <= 1'b0;
        end else if (i_clk_ce) begin
            cmd_r      <= cmd_s;
            mem_req_r  <= mem_req_s;
            if_data_r  <= if_data_s;
            ls_rdata_r <= ls_rdata_s;
            if_valid_r <= if_valid_s;
            ls_ack_r   <= ls_ack_s;
        end
    end

    assign o_mem_req   = mem_req_r;
    assign o_mem_we    = cmd_r.we;
    assign o_mem_addr  = cmd_r.addr;
    assign o_mem_wdata = cmd_r.wdata;
    assign o_mem_wstrb = cmd_r.wstrb;
    assign o_if_data   = if_data_r;
    assign o_if_valid  = if_valid_r;
    assign o_ls_rdata  = ls_rdata_r;
    assign o_ls_ack    = ls_ack_r;
    // The core's stall term must see a new request in the same cycle
    assign o_hz_mem    = if_elig_s || ls_elig_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed test-plan scenarios followed by
// randomized traffic, scored against a transaction-level model with a memory array.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst, i_clk_ce;
    logic        i_if_req, i_br_en, i_ls_req, i_ls_we, i_mem_ack;
    logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
    logic [3:0]  i_ls_wstrb;
    logic [31:0] o_if_data, o_ls_rdata, o_mem_addr, o_mem_wdata;
    logic        o_if_valid, o_ls_ack, o_mem_req, o_mem_we, o_hz_mem;
    logic [3:0]  o_mem_wstrb;

    mem_arbiter u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_ce(i_clk_ce),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_br_en(i_br_en),
        .o_if_data(o_if_data), .o_if_valid(o_if_valid),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_wstrb(i_ls_wstrb),
        .o_ls_rdata(o_ls_rdata), .o_ls_ack(o_ls_ack),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack), .o_hz_mem(o_hz_mem)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference memory: untouched words read as a fixed function of the address
    logic [31:0] mem_m [bit [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        cur = mem_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        mem_m[a] = cur;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'h0000_2000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // Transaction-level model: who holds the bus, what it must show, what returns
    int          owner;        // 0 none, 1 fetch, 2 load/store
    bit          last_ls, flushed, exp_if_v, exp_ls_a;
    int          waits, wait_fix, if_pulses;
    bit          auto_req, ghost_force, if_fin, ls_fin;
    logic [31:0] exp_if_data, exp_ls_rdata, exp_addr, exp_wdata;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] grant_log [$];

    task automatic cycle();
        bit if_el, ls_el, granted;
        if (!i_rst && owner != 0 && i_clk_ce && waits == 0) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = mem_rd(o_mem_addr);
        end else begin
            i_mem_ack   = ghost_force || (!i_clk_ce && owner != 0 && $urandom_range(0, 1) == 1);
            i_mem_rdata = $urandom;
        end
        if_el   = i_if_req && !exp_if_v;
        ls_el   = i_ls_req && !exp_ls_a;
        granted = 1'b0;
        @(posedge i_clk);
        #1;
        if (i_rst) begin
            owner = 0; last_ls = 1'b0; flushed = 1'b0; waits = 0;
            exp_if_v = 1'b0; exp_ls_a = 1'b0;
            exp_if_data = 32'h0; exp_ls_rdata = 32'h0;
        end else if (i_clk_ce) begin
            exp_if_v = 1'b0;
            exp_ls_a = 1'b0;
            if (owner == 1) begin
                if (i_br_en) flushed = 1'b1;
                if (i_mem_ack) begin
                    if (!flushed) begin
                        exp_if_v    = 1'b1;
                        exp_if_data = mem_rd(exp_addr);
                    end
                    flushed = 1'b0; owner = 0; last_ls = 1'b0;
                end else waits--;
            end else if (owner == 2) begin
                if (i_mem_ack) begin
                    exp_ls_a = 1'b1;
                    if (exp_we) mem_wr(exp_addr, exp_wdata, exp_wstrb);
                    else exp_ls_rdata = mem_rd(exp_addr);
                    owner = 0; last_ls = 1'b1;
                end else waits--;
            end else if (if_el && (!ls_el || last_ls)) begin
                owner = 1; granted = 1'b1;
                exp_addr = i_if_addr & 32'hFFFF_FFFC; exp_we = 1'b0; exp_wstrb = 4'b0000;
            end else if (ls_el) begin
                owner = 2; granted = 1'b1;
                exp_addr = i_ls_addr & 32'hFFFF_FFFC; exp_we = i_ls_we;
                exp_wdata = i_ls_wdata; exp_wstrb = i_ls_we ? i_ls_wstrb : 4'b0000;
            end
            if (granted) begin
                waits = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
                grant_log.push_back(exp_addr);
            end
        end
        check_eq("mem_req", 32'(o_mem_req), 32'(owner != 0));
        if (owner != 0) begin
            check_eq("mem_addr", o_mem_addr, exp_addr);
            check_eq("mem_we", 32'(o_mem_we), 32'(exp_we));
            check_eq("mem_wstrb", 32'(o_mem_wstrb), 32'(exp_wstrb));
            if (exp_we) check_eq("mem_wdata", o_mem_wdata, exp_wdata);
        end
        check_eq("if_valid", 32'(o_if_valid), 32'(exp_if_v));
        if (exp_if_v) check_eq("if_data", o_if_data, exp_if_data);
        check_eq("ls_ack", 32'(o_ls_ack), 32'(exp_ls_a));
        if (exp_ls_a) check_eq("ls_rdata", o_ls_rdata, exp_ls_rdata);
        check_eq("hz_mem", 32'(o_hz_mem),
                 32'((i_if_req && !exp_if_v) || (i_ls_req && !exp_ls_a)));
        if (o_if_valid) if_pulses++;
        if (!auto_req) begin
            if (exp_if_v) i_if_req = 1'b0;
            if (exp_ls_a) i_ls_req = 1'b0;
        end
    endtask

    task automatic drive_random();
        i_br_en  = 1'b0;
        i_clk_ce = (owner != 0 && $urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
        if (exp_if_v) begin
            if_fin = 1'b1;
            if ($urandom_range(0, 1) == 0) i_if_req = 1'b0;
        end else if (if_fin || !i_if_req) begin
            if_fin    = 1'b0;
            i_if_req  = ($urandom_range(0, 2) != 0);
            i_if_addr = rnd_addr();
        end else if (i_clk_ce && $urandom_range(0, 9) == 0) begin
            i_br_en   = 1'b1;
            i_if_addr = rnd_addr();
        end
        if (exp_ls_a) begin
            ls_fin = 1'b1;
            if ($urandom_range(0, 1) == 0) i_ls_req = 1'b0;
        end else if (ls_fin || !i_ls_req) begin
            ls_fin     = 1'b0;
            i_ls_req   = ($urandom_range(0, 2) != 0);
            i_ls_we    = 1'($urandom_range(0, 1));
            i_ls_addr  = rnd_addr();
            i_ls_wdata = $urandom;
            i_ls_wstrb = 4'($urandom_range(1, 15));
        end
    endtask

    initial begin
        i_rst = 1'b1; i_clk_ce = 1'b1; i_if_req = 1'b0; i_br_en = 1'b0;
        i_ls_req = 1'b0; i_ls_we = 1'b0; i_mem_ack = 1'b0;
        i_if_addr = 32'h0; i_ls_addr = 32'h0; i_ls_wdata = 32'h0; i_mem_rdata = 32'h0;
        i_ls_wstrb = 4'h0;
        owner = 0; last_ls = 1'b0; flushed = 1'b0; exp_if_v = 1'b0; exp_ls_a = 1'b0;
        waits = 0; wait_fix = -1; if_pulses = 0; auto_req = 1'b0; ghost_force = 1'b0;
        if_fin = 1'b0; ls_fin = 1'b0; exp_if_data = 32'h0; exp_ls_rdata = 32'h0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_we = 1'b0; exp_wstrb = 4'h0;

        repeat (2) cycle();
        i_rst = 1'b0;
        cycle();
        check_eq("rst_if_data", o_if_data, 32'h0);
        check_eq("rst_ls_rdata", o_ls_rdata, 32'h0);
        check_eq("rst_mem_addr", o_mem_addr, 32'h0);
        check_eq("rst_mem_wstrb", 32'(o_mem_wstrb), 32'h0);

        // Fetch only, zero-wait slave
        mem_m[32'h104] = 32'h00A0_0093;
        wait_fix = 0; if_pulses = 0; grant_log.delete();
        i_if_req = 1'b1; i_if_addr = 32'h0000_0104;
        repeat (5) cycle();
        check_eq("tp_fetch_done", 32'(i_if_req), 32'h0);
        check_eq("tp_fetch_addr", grant_log[0], 32'h0000_0104);
        check_eq("tp_fetch_pulses", 32'(if_pulses), 32'h1);
        check_eq("tp_fetch_data", o_if_data, 32'h00A0_0093);

        // First tie after reset goes to load/store
        grant_log.delete();
        i_if_req = 1'b1; i_if_addr = 32'h10;
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h2002;
        repeat (10) cycle();
        check_eq("tp_tie1_n", 32'(grant_log.size()), 32'h2);
        check_eq("tp_tie1_first", grant_log[0], 32'h2000);
        check_eq("tp_tie1_second", grant_log[1], 32'h10);

        // Store with a 3-wait slave; fields checked stable every cycle
        grant_log.delete(); wait_fix = 3;
        i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_addr = 32'h3004;
        i_ls_wdata = 32'hDEAD_BEEF; i_ls_wstrb = 4'b1100;
        repeat (10) cycle();
        check_eq("tp_store_done", 32'(i_ls_req), 32'h0);
        check_eq("tp_store_addr", grant_log[0], 32'h3004);

        // Tie with load/store served last: fetch goes first
        grant_log.delete(); wait_fix = 1;
        i_if_req = 1'b1; i_if_addr = 32'h20;
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h3004;
        repeat (12) cycle();
        check_eq("tp_tie2_first", grant_log[0], 32'h20);
        check_eq("tp_tie2_second", grant_log[1], 32'h3004);
        check_eq("tp_tie2_merged", o_ls_rdata, {32'hDEAD_BEEF & 32'hFFFF_0000} | (mem_rd(32'h3004) & 32'h0000_FFFF));

        // Branch while fetch is in flight on a 2-wait slave
        grant_log.delete(); wait_fix = 2; if_pulses = 0;
        i_if_req = 1'b1; i_if_addr = 32'h40;
        cycle();
        i_br_en = 1'b1; i_if_addr = 32'h80;
        cycle();
        i_br_en = 1'b0;
        repeat (10) cycle();
        check_eq("tp_flush_n", 32'(grant_log.size()), 32'h2);
        check_eq("tp_flush_next", grant_log[1], 32'h80);
        check_eq("tp_flush_pulses", 32'(if_pulses), 32'h1);
        check_eq("tp_flush_data", o_if_data, mem_rd(32'h80));

        // Branch coinciding with the ack
        grant_log.delete(); wait_fix = 0; if_pulses = 0;
        i_if_req = 1'b1; i_if_addr = 32'h44;
        cycle();
        i_br_en = 1'b1; i_if_addr = 32'h48;
        cycle();
        i_br_en = 1'b0;
        repeat (6) cycle();
        check_eq("tp_brack_next", grant_log[1], 32'h48);
        check_eq("tp_brack_pulses", 32'(if_pulses), 32'h1);

        // Clock enable low for 4 cycles with spurious acks
        grant_log.delete(); wait_fix = 1;
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h2010;
        cycle();
        i_clk_ce = 1'b0; ghost_force = 1'b1;
        repeat (4) cycle();
        ghost_force = 1'b0; i_clk_ce = 1'b1;
        repeat (6) cycle();
        check_eq("tp_ce_done", 32'(i_ls_req), 32'h0);
        check_eq("tp_ce_grants", 32'(grant_log.size()), 32'h1);

        // Randomized traffic
        auto_req = 1'b1; if_fin = 1'b0; ls_fin = 1'b0; wait_fix = -1;
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end
        auto_req = 1'b0; i_br_en = 1'b0; i_clk_ce = 1'b1;
        if (exp_if_v || if_fin) i_if_req = 1'b0;
        if (exp_ls_a || ls_fin) i_ls_req = 1'b0;
        repeat (30) cycle();
        check_eq("drain", 32'(i_if_req || i_ls_req), 32'h0);

        // Reset while a load is in flight, then an ack as reset lifts
        wait_fix = 10;
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h2020;
        repeat (2) cycle();
        i_rst = 1'b1; i_ls_req = 1'b0;
        cycle();
        i_rst = 1'b0;
        check_eq("tp_rst_mem_req", 32'(o_mem_req), 32'h0);
        check_eq("tp_rst_ls_ack", 32'(o_ls_ack), 32'h0);
        check_eq("tp_rst_hz", 32'(o_hz_mem), 32'h0);
        ghost_force = 1'b1;
        cycle();
        ghost_force = 1'b0;
        check_eq("tp_rst_ghost_ack", 32'(o_ls_ack), 32'h0);
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
